ir_sweep_ctrl: RTL
==================

# ir_sweep_ctrl

Parametrised IR-sensor sweep controller for the test-motor rig. It drives a carriage forward past `N_SENS` beam sensors, waits at the far end, reverses, and returns home. It repeats this round trip a programmable number of times, with programmable dwell, a per-step watchdog, and abort. It sits between the raw IR sensor inputs and the motor driver's `en`/`dir` pins.

## Interface
- `N_SENS`, default 3: number of IR sensors, ≥2. `ir[0]` is nearest home, `ir[N_SENS-1]` is farthest.
- `DLY_W`, default 21: width of the dwell counter and of the `dwell` input.
- `CYC_W`, default 8: width of the `cycles` input and of `cyc_done`.
- `TO_W`, default 24: width of the watchdog counter.
- `TIMEOUT`, default 2^24-1: watchdog limit, in cycles. Must be ≥1.
- `CLK`, in, 1: system clock. One clock domain only.
- `RSTn`, in, 1: asynchronous, active-low reset.
- `ir`, in, N_SENS: asynchronous beam inputs. Idle is high; a blocked beam is low.
- `start`, in, 1: single-cycle pulse that begins a run. Honoured only in IDLE.
- `abort`, in, 1: single-cycle pulse that forces IDLE from any state.
- `cycles`, in, CYC_W: number of round trips. Latched at start. 0 means run continuously until abort.
- `dwell`, in, DLY_W: dwell length in cycles at the far end. Latched at start. 0 is treated as 1.
- `en`, out, 1: motor enable.
- `dir`, out, 1: motor direction. 1 is forward, 0 is backward.
- `busy`, out, 1: high in any state other than IDLE or FAULT.
- `done`, out, 1: one-cycle pulse when a run completes normally.
- `fault`, out, 1: high while in FAULT.
- `cyc_done`, out, CYC_W: count of completed round trips in the current run.

## Operation
- **Input synchronisation.** Each `ir` bit passes through a 2-flop synchroniser followed by a history flop (s1→s2→s3), all reset to 1.
  - `rise[k] = s2 & ~s3`; `fall[k] = ~s2 & s3`.
- **States.** IDLE, FW_FALL, FW_RISE, END, DWELL, BW_FALL, BW_RISE, FAULT. A step index `idx` selects which sensor the current state is waiting on.
- **Transitions:**
  - IDLE → FW_FALL on `start`; `idx`=0. `cycles` and `dwell` are latched; `cyc_done` is cleared.
  - FW_FALL waits for `fall[idx]`, then increments `idx`. When `idx` = N_SENS-1 it goes to FW_RISE with `idx`=0.
  - FW_RISE waits for `rise[idx]`, then increments `idx`. When `idx` = N_SENS-1 it goes to END.
  - END waits for `fall[N_SENS-1]`, then goes to DWELL.
  - DWELL counts from 0 and exits when count = max(dwell,1)-1. It goes to BW_FALL with `idx` = N_SENS-2.
  - BW_FALL waits for `fall[idx]`, then decrements `idx`. When `idx` = 0 it goes to BW_RISE with `idx` = N_SENS-1.
  - BW_RISE waits for `rise[idx]`, then decrements `idx`. When `idx` = 0, `cyc_done` increments (it wraps at 2^CYC_W), and then:
    - if `cycles`≠0 and `cyc_done`+1 = `cycles`: go to IDLE and pulse `done`;
    - otherwise go to FW_FALL with `idx`=0.
- **Edge filtering.** Only the edge on the selected sensor and polarity is acted on. All other edges are ignored.
- **Watchdog.** The counter clears on every state or `idx` change and counts in every state except IDLE, DWELL and FAULT. When the count reaches `TIMEOUT`, the block goes to FAULT.
- **FAULT** holds until `abort`, which returns the block to IDLE. `start` is ignored in FAULT.
- **Priority:** `abort` > watchdog > edge advance. `abort` together with `start` in IDLE leaves the block in IDLE.
- **Outputs** are registered and are functions of the state:
  - `en` = 1 in all states except IDLE and FAULT.
  - `dir` = 1 in IDLE, FW_FALL and FW_RISE; `dir` = 0 in END, DWELL, BW_FALL and BW_RISE. In FAULT, `dir` holds its previous value.

## Timing
- **Reset values.** State IDLE, `en`=0, `dir`=1, `busy`=0, `done`=0, `fault`=0, `cyc_done`=0. Synchroniser flops and all counters reset to their reset values.
- **Reset mid-run.** The block goes to IDLE immediately, asynchronously. No `done` pulse is issued.
- **`ir` to state latency.** A level change on `ir` that is stable before CLK edge k advances the state at edge k+2. `en`/`dir` change at that same edge.
- **`start` latency.** `start` high at edge k gives `en`=1, `busy`=1 and `dir`=1 after edge k.
- **`abort` latency.** `abort` high at edge k gives `en`=0 and `busy`=0 after edge k.
- **`done`** is high for exactly the one cycle following the edge on which the block returns to IDLE.
- **DWELL** lasts exactly max(`dwell`,1) cycles.
- **Watchdog.** FAULT is entered exactly `TIMEOUT` cycles after entering a waiting step with no qualifying edge.

## Test plan
- **Single trip.** N_SENS=3, `cycles`=1, `dwell`=4. Drive the ideal edge sequence: fall 0,1,2; rise 0,1,2; fall 2; fall 1,0; rise 2,1,0. Required: `dir` drops on END entry, DWELL lasts 4 cycles, `done` pulses once, `cyc_done`=1, `en`=0.
- **Multi-cycle and continuous.** With `cycles`=3, run three sequences: `done` pulses only after the third. With `cycles`=0, run five sequences and then abort: `cyc_done`=5, no `done`.
- **Out-of-order edges.** Inject `fall[2]` during FW_FALL with `idx`=0. Required: no advance; the correct `fall[0]` then advances.
- **Watchdog.** `TIMEOUT`=100; stall in FW_RISE. Required: `fault`=1 and `en`=0 at cycle 100. `start` is ignored in FAULT; `abort` gives IDLE.
- **Abort and reset.** `abort` in DWELL gives `en`=0 on the next cycle and no `done`. Asserting `RSTn` low mid BW_FALL clears all outputs to their reset values asynchronously.
- **Synchroniser behaviour.** A 1-cycle glitch on `ir`, and `ir` held low through reset. Required: state advances 2 edges after a stable change, and no spurious edge is detected at reset release when `ir`=1.

Source files
------------

// File: rtl/ir_sweep_ctrl.sv
// IR-sensor sweep controller: drives a carriage forward past N_SENS beam sensors,
// dwells at the far end, returns home, and repeats for a programmable number of
// round trips. Includes a per-step watchdog and an abort path.
module ir_sweep_ctrl #(
  parameter int unsigned N_SENS  = 3,
  parameter int unsigned DLY_W   = 21,
  parameter int unsigned CYC_W   = 8,
  parameter int unsigned TO_W    = 24,
  parameter int unsigned TIMEOUT = (1 << 24) - 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_SENS-1:0] ir,
  input  logic              start,
  input  logic              abort,
  input  logic [CYC_W-1:0]  cycles,
  input  logic [DLY_W-1:0]  dwell,
  output logic              en,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [CYC_W-1:0]  cyc_done
);

  localparam int unsigned IdxW = $clog2(N_SENS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_SENS - 1);
  localparam logic [IdxW-1:0] IdxPen  = IdxW'(N_SENS - 2);
  localparam logic [TO_W-1:0] WdLast  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFwFall,
    StFwRise,
    StEnd,
    StDwell,
    StBwFall,
    StBwRise,
    StFault
  } state_e;

  // Synchroniser chain (s1, s2) plus history flop (s3); idle beam level is 1.
  logic [N_SENS-1:0] s1_q, s2_q, s3_q;
  logic [N_SENS-1:0] s1_d, s2_d, s3_d;
  logic [N_SENS-1:0] rise, fall;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d;
  logic [CYC_W-1:0]  cyc_done_q, cyc_done_d;
  logic [DLY_W-1:0]  dwell_lim_q, dwell_lim_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              en_q, en_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic              sel_fall, sel_rise, wd_expired;
  logic [CYC_W-1:0]  cyc_inc;

  // Next value of the synchroniser / history chain.
  always_comb begin
    s1_d = ir;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_q <= '1;
      s2_q <= '1;
      s3_q <= '1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign sel_fall   = fall[idx_q];
  assign sel_rise   = rise[idx_q];
  assign wd_expired = (wd_q == WdLast);
  assign cyc_inc    = cyc_done_q + CYC_W'(1);

  // Sequencing FSM: next state, step index, run bookkeeping and done pulse.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cycles_d    = cycles_q;
    cyc_done_d  = cyc_done_q;
    dwell_lim_d = dwell_lim_q;
    done_d      = 1'b0;

    if (abort) begin
      // Abort beats everything, including a coincident start in IDLE.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StFwFall;
            idx_d       = '0;
            cycles_d    = cycles;
            cyc_done_d  = '0;
            // A dwell of 0 behaves as 1; store the terminal count.
            dwell_lim_d = (dwell == '0) ? '0 : dwell - DLY_W'(1);
          end
        end
        StFwFall: begin
          if (wd_expired) begin
            state_d = StFault;
          end else if (sel_fall) begin
            if (idx_q == IdxLast) begin
              state_d = StFwRise;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        StFwRise: begin
          if (wd_expired) begin
            state_d = StFault;
          end else if (sel_rise) begin
            if (idx_q == IdxLast) begin
              state_d = StEnd;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        StEnd: begin
          if (wd_expired) begin
            state_d = StFault;
          end else if (fall[N_SENS-1]) begin
            state_d = StDwell;
          end
        end
        StDwell: begin
          if (dly_q == dwell_lim_q) begin
            state_d = StBwFall;
            idx_d   = IdxPen;
          end
        end
        StBwFall: begin
          if (wd_expired) begin
            state_d = StFault;
          end else if (sel_fall) begin
            if (idx_q == '0) begin
              state_d = StBwRise;
              idx_d   = IdxLast;
            end else begin
              idx_d = idx_q - IdxW'(1);
            end
          end
        end
        StBwRise: begin
          if (wd_expired) begin
            state_d = StFault;
          end else if (sel_rise) begin
            if (idx_q == '0) begin
              cyc_done_d = cyc_inc;
              if ((cycles_q != '0) && (cyc_inc == cycles_q)) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                state_d = StFwFall;
                idx_d   = '0;
              end
            end else begin
              idx_d = idx_q - IdxW'(1);
            end
          end
        end
        StFault: begin
          state_d = StFault;
        end
      endcase
    end
  end

  // Watchdog and dwell counters.
  always_comb begin
    wd_d  = wd_q + TO_W'(1);
    dly_d = '0;
    if ((state_d != state_q) || (idx_d != idx_q) ||
        (state_q inside {StIdle, StDwell, StFault})) begin
      wd_d = '0;
    end
    if ((state_q == StDwell) && (state_d == StDwell)) begin
      dly_d = dly_q + DLY_W'(1);
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    en_d    = !(state_d inside {StIdle, StFault});
    busy_d  = en_d;
    fault_d = (state_d == StFault);
    dir_d   = dir_q;
    unique case (state_d)
      StIdle, StFwFall, StFwRise:         dir_d = 1'b1;
      StEnd, StDwell, StBwFall, StBwRise: dir_d = 1'b0;
      StFault:                            dir_d = dir_q;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cycles_q    <= '0;
      cyc_done_q  <= '0;
      dwell_lim_q <= '0;
      dly_q       <= '0;
      wd_q        <= '0;
      en_q        <= 1'b0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cycles_q    <= cycles_d;
      cyc_done_q  <= cyc_done_d;
      dwell_lim_q <= dwell_lim_d;
      dly_q       <= dly_d;
      wd_q        <= wd_d;
      en_q        <= en_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign en       = en_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign cyc_done = cyc_done_q;

endmodule
